// File: rtl/irda_fir_rx.sv
// FIR (4 Mb/s, 4PPM) receiver: preamble hunt and symbol-phase lock, STA/STO
// flag detection and 4PPM-to-byte decoding. CRC bytes pass through as data.
module irda_fir_rx #(
  parameter int MIN_PA    = 4,
  parameter int MAX_BYTES = 2054
) (
  input  logic       clk,
  input  logic       wb_rst_n_i,
  input  logic       fir_rx8_enable,
  input  logic       rx_en,
  input  logic       fir_rx_i,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_start,
  output logic       rx_frame_end,
  output logic [2:0] rx_err,
  output logic       rx_busy
);

  localparam int BCW = $clog2(MAX_BYTES + 1);
  localparam logic [15:0] PA_PAT  = 16'b1000_0000_1010_1000;
  localparam logic [31:0] STA_PAT = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
  localparam logic [31:0] STO_PAT = 32'b0000_1100_0000_1100_0110_0000_0000_0110;

  typedef enum logic [1:0] {HUNT, PA, DATA} state_t;

  state_t         state, state_nx;
  logic [31:0]    window, window_nx, win_s;
  logic [1:0]     phase, phase_nx;
  logic [3:0]     pa_cnt, pa_cnt_nx;
  logic [3:0]     sym_cnt, sym_cnt_nx, sym_k;
  logic [3:0]     skip, skip_nx;
  logic [2:0]     bit_cnt, bit_cnt_nx;
  logic [7:0]     shreg, shreg_nx;
  logic [BCW-1:0] byte_cnt, byte_cnt_nx;
  logic [7:0]     data_nx;
  logic           valid_nx, start_nx, end_nx;
  logic [2:0]     err_nx;
  logic           boundary, sym_ok;
  logic [1:0]     sym_val;

  assign win_s    = {window[30:0], fir_rx_i};
  assign boundary = (phase == 2'd3);
  // sym_cnt holds symbols since the last PA match minus one; sym_k is the count at this boundary
  assign sym_k    = sym_cnt + 4'd1;
  assign rx_busy  = (state != HUNT);

  always_comb begin
    sym_ok  = 1'b1;
    sym_val = 2'd0;
    case (win_s[31:28])
      4'b1000: sym_val = 2'd0;
      4'b0100: sym_val = 2'd1;
      4'b0010: sym_val = 2'd2;
      4'b0001: sym_val = 2'd3;
      default: sym_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nx    = state;
    window_nx   = window;
    phase_nx    = phase;
    pa_cnt_nx   = pa_cnt;
    sym_cnt_nx  = sym_cnt;
    skip_nx     = skip;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    byte_cnt_nx = byte_cnt;
    data_nx     = rx_data;
    err_nx      = rx_err;
    valid_nx    = 1'b0;
    start_nx    = 1'b0;
    end_nx      = 1'b0;
    if (!rx_en) begin
      state_nx    = HUNT;
      window_nx   = '0;
      phase_nx    = '0;
      pa_cnt_nx   = '0;
      sym_cnt_nx  = '0;
      skip_nx     = '0;
      bit_cnt_nx  = '0;
      shreg_nx    = '0;
      byte_cnt_nx = '0;
      if (state != HUNT) begin
        end_nx = 1'b1;
        err_nx = 3'b100;
      end
    end else if (fir_rx8_enable) begin
      window_nx = win_s;
      phase_nx  = phase + 2'd1;
      case (state)
        HUNT: begin
          if (win_s[15:0] == PA_PAT) begin
            phase_nx   = '0;
            pa_cnt_nx  = 4'd1;
            sym_cnt_nx = '0;
            state_nx   = PA;
          end
        end
        PA: begin
          if (boundary) begin
            if (win_s == STA_PAT) begin
              if (int'(pa_cnt) >= MIN_PA) begin
                start_nx    = 1'b1;
                state_nx    = DATA;
                // STA occupies the window; its remaining 7 symbols leave before the first data symbol
                skip_nx     = 4'd7;
                bit_cnt_nx  = '0;
                byte_cnt_nx = '0;
              end else begin
                state_nx = HUNT;
              end
            end else if (sym_k[1:0] == 2'd0 && win_s[15:0] == PA_PAT) begin
              if (pa_cnt != 4'd15) pa_cnt_nx = pa_cnt + 4'd1;
              sym_cnt_nx = '0;
            end else if (sym_k == 4'd8) begin
              state_nx = HUNT;
            end else begin
              sym_cnt_nx = sym_k;
            end
          end
        end
        DATA: begin
          if (boundary) begin
            if (win_s == STO_PAT) begin
              end_nx   = 1'b1;
              err_nx   = (bit_cnt != 3'd0) ? 3'b010 : 3'b000;
              state_nx = HUNT;
            end else if (skip != 4'd0) begin
              skip_nx = skip - 4'd1;
            end else if (!sym_ok) begin
              end_nx   = 1'b1;
              err_nx   = 3'b001;
              state_nx = HUNT;
            end else begin
              shreg_nx   = {sym_val, shreg[7:2]};
              bit_cnt_nx = bit_cnt + 3'd2;
              if (bit_cnt == 3'd6) begin
                data_nx     = {sym_val, shreg[7:2]};
                valid_nx    = 1'b1;
                byte_cnt_nx = byte_cnt + BCW'(1);
                if (byte_cnt == BCW'(MAX_BYTES - 1)) begin
                  end_nx   = 1'b1;
                  err_nx   = 3'b011;
                  state_nx = HUNT;
                end
              end
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state          <= HUNT;
      window         <= '0;
      phase          <= '0;
      pa_cnt         <= '0;
      sym_cnt        <= '0;
      skip           <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      byte_cnt       <= '0;
      rx_data        <= '0;
      rx_data_valid  <= 1'b0;
      rx_frame_start <= 1'b0;
      rx_frame_end   <= 1'b0;
      rx_err         <= '0;
    end else begin
      state          <= state_nx;
      window         <= window_nx;
      phase          <= phase_nx;
      pa_cnt         <= pa_cnt_nx;
      sym_cnt        <= sym_cnt_nx;
      skip           <= skip_nx;
      bit_cnt        <= bit_cnt_nx;
      shreg          <= shreg_nx;
      byte_cnt       <= byte_cnt_nx;
      rx_data        <= data_nx;
      rx_data_valid  <= valid_nx;
      rx_frame_start <= start_nx;
      rx_frame_end   <= end_nx;
      rx_err         <= err_nx;
    end
  end

endmodule

// File: tb/tb_irda_fir_rx.sv
// Bench for irda_fir_rx: two receivers (default and MAX_BYTES=4) see the same
// randomized frames and are compared against a frame-level reference model.
module tb_irda_fir_rx;

  localparam logic [15:0] PA_C  = 16'b1000_0000_1010_1000;
  localparam logic [31:0] STA_C = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
  localparam logic [31:0] STO_C = 32'b0000_1100_0000_1100_0110_0000_0000_0110;

  logic       clk = 1'b0;
  logic       rst_n, strobe, rx_en, rx_i;
  logic [7:0] rx_data [2];
  logic [2:0] rx_err [2];
  logic [1:0] valid, fstart, fend, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int sent = 0;

  int         n_start [2] = '{0, 0};
  int         n_end [2]   = '{0, 0};
  int         n_got [2]   = '{0, 0};
  int         end_err [2] = '{0, 0};
  int         end_chip [2] = '{0, 0};
  logic [7:0] got [2][1024];

  logic [3:0] syms [64];
  int         nsym;
  int         last_chip [64];

  irda_fir_rx #(.MIN_PA(4), .MAX_BYTES(2054)) u_dut (
    .clk(clk), .wb_rst_n_i(rst_n), .fir_rx8_enable(strobe), .rx_en(rx_en),
    .fir_rx_i(rx_i), .rx_data(rx_data[0]), .rx_data_valid(valid[0]),
    .rx_frame_start(fstart[0]), .rx_frame_end(fend[0]), .rx_err(rx_err[0]),
    .rx_busy(busy[0])
  );

  irda_fir_rx #(.MIN_PA(4), .MAX_BYTES(4)) u_ovf (
    .clk(clk), .wb_rst_n_i(rst_n), .fir_rx8_enable(strobe), .rx_en(rx_en),
    .fir_rx_i(rx_i), .rx_data(rx_data[1]), .rx_data_valid(valid[1]),
    .rx_frame_start(fstart[1]), .rx_frame_end(fend[1]), .rx_err(rx_err[1]),
    .rx_busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && fstart[k]) n_start[k]++;
      if (rst_n && valid[k]) begin
        if (n_got[k] < 1024) got[k][n_got[k]] = rx_data[k];
        n_got[k]++;
      end
      if (rst_n && fend[k]) begin
        n_end[k]++;
        end_err[k]  = int'(rx_err[k]);
        end_chip[k] = sent;
      end
    end
  end

  task automatic check(input string tag, input int got_v, input int exp_v);
    n_cmp++;
    if (got_v != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic chip(input logic b);
    @(negedge clk);
    rx_i = b;
    strobe = 1'b1;
    sent++;
    @(negedge clk);
    strobe = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) chip(v[i]);
  endtask

  task automatic add_sym(input logic [3:0] s);
    syms[nsym] = s;
    nsym++;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int p = 0; p < 4; p++) add_sym(4'b1000 >> b[2*p +: 2]);
  endtask

  function automatic int sym_idx(input logic [3:0] s);
    for (int j = 0; j < 4; j++) if (s == (4'b1000 >> j)) return j;
    return -1;
  endfunction

  task automatic send_body(input int npa);
    for (int p = 0; p < npa; p++) send_bits({16'd0, PA_C}, 16);
    send_bits(STA_C, 32);
    for (int i = 0; i < nsym; i++) begin
      send_bits({28'd0, syms[i]}, 4);
      last_chip[i] = sent;
    end
  endtask

  task automatic run_frame(input int npa, input bit abort);
    int s0 [2], e0 [2], g0 [2];
    int sto_last, ncons, bits, nb, m, e_err, e_chip, e_start, e_end, v, ng;
    bit stopped;
    logic [7:0] acc;
    logic [7:0] exp_b [64];
    sto_last = -1;
    for (int i = 0; i < 40; i++) chip(1'b0);
    for (int k = 0; k < 2; k++) begin
      s0[k] = n_start[k];
      e0[k] = n_end[k];
      g0[k] = n_got[k];
    end
    send_body(npa);
    if (!abort) begin
      send_bits(STO_C, 32);
      sto_last = sent;
    end else begin
      @(negedge clk);
      rx_en = 1'b0;
      repeat (3) @(negedge clk);
      rx_en = 1'b1;
    end
    for (int i = 0; i < 40; i++) chip(1'b0);

    for (int k = 0; k < 2; k++) begin
      m = (k == 0) ? 2054 : 4;
      e_start = (npa >= 4) ? 1 : 0;
      e_end = 0; e_err = 0; e_chip = -1; nb = 0; bits = 0; acc = '0; stopped = 1'b0;
      if (e_start == 1) begin
        // a data symbol is consumed 32 chips after its first chip; abort cuts off the last 7
        ncons = abort ? nsym - 7 : nsym;
        for (int i = 0; i < ncons && !stopped; i++) begin
          v = sym_idx(syms[i]);
          if (v < 0) begin
            stopped = 1'b1; e_end = 1; e_err = 1; e_chip = last_chip[i] + 28;
          end else begin
            acc = acc | (8'(v) << bits);
            bits += 2;
            if (bits == 8) begin
              exp_b[nb] = acc; nb++; acc = '0; bits = 0;
              if (nb == m) begin
                stopped = 1'b1; e_end = 1; e_err = 3; e_chip = last_chip[i] + 28;
              end
            end
          end
        end
        if (!stopped) begin
          e_end  = 1;
          e_err  = abort ? 4 : ((bits != 0) ? 2 : 0);
          e_chip = abort ? -1 : sto_last;
        end
      end
      ng = n_got[k] - g0[k];
      check($sformatf("start[%0d]", k), n_start[k] - s0[k], e_start);
      check($sformatf("nbytes[%0d]", k), ng, nb);
      for (int j = 0; j < ng && j < nb; j++)
        check($sformatf("byte%0d[%0d]", j, k), int'(got[k][g0[k] + j]), int'(exp_b[j]));
      check($sformatf("nend[%0d]", k), n_end[k] - e0[k], e_end);
      if (e_end == 1 && n_end[k] - e0[k] == 1) begin
        check($sformatf("err[%0d]", k), end_err[k], e_err);
        if (e_chip >= 0) check($sformatf("endchip[%0d]", k), end_chip[k], e_chip);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_data[%0d]", tag, k), int'(rx_data[k]), 0);
      check($sformatf("%s_valid[%0d]", tag, k), int'(valid[k]), 0);
      check($sformatf("%s_start[%0d]", tag, k), int'(fstart[k]), 0);
      check($sformatf("%s_end[%0d]", tag, k), int'(fend[k]), 0);
      check($sformatf("%s_err[%0d]", tag, k), int'(rx_err[k]), 0);
      check($sformatf("%s_busy[%0d]", tag, k), int'(busy[k]), 0);
    end
  endtask

  logic [3:0] bad_codes [5] = '{4'b1100, 4'b0110, 4'b1111, 4'b0000, 4'b1010};

  initial begin
    int npa, nbytes;
    bit abort;
    rst_n = 1'b0; strobe = 1'b0; rx_en = 1'b0; rx_i = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    rx_en = 1'b1;

    nsym = 0; add_byte(8'hA5); add_byte(8'h3C);
    run_frame(16, 1'b0);

    nsym = 0; add_byte(8'h12); add_byte(8'h34);
    run_frame(2, 1'b0);
    nsym = 0; add_byte(8'h96);
    run_frame(6, 1'b0);

    nsym = 0; add_byte(8'h11); add_byte(8'h22); add_byte(8'h33);
    syms[2] = 4'b1100;
    run_frame(8, 1'b0);

    nsym = 0; add_byte(8'h55); add_sym(4'b0100);
    run_frame(4, 1'b0);

    nsym = 0; add_byte(8'hC1); add_byte(8'h7F); add_byte(8'h08);
    for (int i = 0; i < 8; i++) add_sym(4'b0010);
    run_frame(8, 1'b1);

    nsym = 0;
    for (int i = 0; i < 6; i++) add_byte(8'(8'h40 + i));
    run_frame(5, 1'b0);

    for (int f = 0; f < 18; f++) begin
      npa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 16);
      nbytes = $urandom_range(0, 6);
      nsym = 0;
      for (int i = 0; i < nbytes; i++) add_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) add_sym(4'b1000 >> $urandom_range(0, 3));
      abort = ($urandom_range(0, 4) == 0);
      if (abort) repeat (8) add_sym(4'b1000 >> $urandom_range(0, 3));
      if (nsym > 0 && $urandom_range(0, 3) == 0)
        syms[$urandom_range(0, nsym - 1)] = bad_codes[$urandom_range(0, 4)];
      run_frame(npa, abort);
    end

    nsym = 0; add_byte(8'h5A); add_byte(8'hC3); add_byte(8'h7E);
    for (int i = 0; i < 8; i++) add_sym(4'b0001);
    for (int i = 0; i < 40; i++) chip(1'b0);
    send_body(8);
    check("mid_busy", int'(busy[0]), 1);
    check("mid_data", int'(rx_data[0]), 8'h7E);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
